jtag_tap_ctrl: RTL and testbench

Parametrised JTAG(esque) test-access-port controller running entirely in the system clock domain. It synchronizes the raw TCK/TMS/TDI pins, edge-detects TCK, runs the full 16-state IEEE-1149.1-style TAP state machine, and provides a parametrised instruction register plus a general data register with capture/update strobes toward the processor's debug logic. It sits directly behind the top-level pins and replaces the fixed-width port behind external per-pin synchronizers.

---
 rtl/jtag_pkg.sv | 55 +++++
 rtl/jtag_tap_fsm.sv | 27 ++
 rtl/jtag_tap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the system-clock-domain TAP controller.
//   tapState_t      : 16 TAP states, 4-bit encodings, TLR = 0
//   IDCODE_OPCODE   : instruction value selecting IDCODE (when enabled)
//   IR_CAPTURE_LSBS : low bits loaded into the IR shift register at Capture-IR
//   tapNext()       : TMS-driven next-state function
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR     = 4'd0,
    RTI     = 4'd1,
    SelDR   = 4'd2,
    CapDR   = 4'd3,
    ShDR    = 4'd4,
    Ex1DR   = 4'd5,
    PauseDR = 4'd6,
    Ex2DR   = 4'd7,
    UpdDR   = 4'd8,
    SelIR   = 4'd9,
    CapIR   = 4'd10,
    ShIR    = 4'd11,
    Ex1IR   = 4'd12,
    PauseIR = 4'd13,
    Ex2IR   = 4'd14,
    UpdIR   = 4'd15
  } tapState_t;

  localparam int unsigned IDCODE_OPCODE   = 1;
  localparam logic [1:0]  IR_CAPTURE_LSBS = 2'b01;

  function automatic tapState_t tapNext(input tapState_t s, input logic tms);
    tapState_t n;
    n = TLR;
    case (s)
      TLR:     n = tms ? TLR   : RTI;
      RTI:     n = tms ? SelDR : RTI;
      SelDR:   n = tms ? SelIR : CapDR;
      CapDR:   n = tms ? Ex1DR : ShDR;
      ShDR:    n = tms ? Ex1DR : ShDR;
      Ex1DR:   n = tms ? UpdDR : PauseDR;
      PauseDR: n = tms ? Ex2DR : PauseDR;
      Ex2DR:   n = tms ? UpdDR : ShDR;
      UpdDR:   n = tms ? SelDR : RTI;
      SelIR:   n = tms ? TLR   : CapIR;
      CapIR:   n = tms ? Ex1IR : ShIR;
      ShIR:    n = tms ? Ex1IR : ShIR;
      Ex1IR:   n = tms ? UpdIR : PauseIR;
      PauseIR: n = tms ? Ex2IR : PauseIR;
      Ex2IR:   n = tms ? UpdIR : ShIR;
      UpdIR:   n = tms ? SelDR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: TAP state register and next-state logic.
//   clk, rst  : system clock, synchronous active-high reset (-> TLR)
//   tms       : synchronized TMS
//   rise      : one-cycle TCK rising-edge strobe; state advances only then
//   state     : current TAP state
//   nextState : state that will be loaded at the next clk edge
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      tms,
  input  logic      rise,
  output tapState_t state,
  output tapState_t nextState
);

  always_comb begin
    nextState = rise ? tapNext(state, tms) : state;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= TLR;
    else     state <= nextState;
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: JTAG-style TAP controller running in the system clock domain.
// Raw TCK/TMS/TDI are synchronized (SYNC_STAGES flops each), TCK is
// edge-detected, and all TAP actions happen on the resulting strobes.
//   i_clk, i_rst       : system clock, synchronous active-high reset
//   i_tck/i_tms/i_tdi  : raw asynchronous JTAG pins
//   o_tdo              : serial out, updated on TCK fall in Shift-DR/IR
//   o_ir               : current instruction
//   i_drIn / o_drOut   : general DR capture value / value latched at Update-DR
//   o_drCapture        : pulse, general DR captured
//   o_drUpdate         : pulse, o_drOut newly valid
//   o_tapState         : current TAP state encoding
// Build option: define JTAG_IDCODE_EN to add the 32-bit IDCODE register
// (opcode 1, default instruction). Otherwise opcode 1 is a general-DR opcode
// and the default instruction is BYPASS.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned IR_W        = 4,
  parameter int unsigned DR_W        = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] IDCODE_VAL  = 32'h0000_5C11
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tck,
  input  logic            i_tms,
  input  logic            i_tdi,
  output logic            o_tdo,
  output logic [IR_W-1:0] o_ir,
  input  logic [DR_W-1:0] i_drIn,
  output logic [DR_W-1:0] o_drOut,
  output logic            o_drCapture,
  output logic            o_drUpdate,
  output logic [3:0]      o_tapState
);

  // IEEE 1149.1 requires IDCODE bit 0 to be 1
  if (IR_W < 2 || DR_W < 2 || SYNC_STAGES < 2 || IDCODE_VAL[0] != 1'b1) begin : gParamCheck
    $error("jtag_tap_ctrl: illegal parameter value");
  end

  localparam logic [IR_W-1:0] BYPASS_OP  = '1;
  localparam logic [IR_W-1:0] IDCODE_OP  = IR_W'(IDCODE_OPCODE);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(IR_CAPTURE_LSBS);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] IR_DEFAULT = IDCODE_OP;
`else
  localparam logic [IR_W-1:0] IR_DEFAULT = BYPASS_OP;
`endif

  // ---------------- pin synchronizers + TCK edge detect ----------------
  logic [SYNC_STAGES-1:0] tckSync, tmsSync, tdiSync;
  logic tckPrev, tck, tms, tdi, rise, fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tckSync <= '0;
      tmsSync <= '0;
      tdiSync <= '0;
      tckPrev <= 1'b0;
    end else begin
      tckSync <= {tckSync[SYNC_STAGES-2:0], i_tck};
      tmsSync <= {tmsSync[SYNC_STAGES-2:0], i_tms};
      tdiSync <= {tdiSync[SYNC_STAGES-2:0], i_tdi};
      tckPrev <= tckSync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    tck  = tckSync[SYNC_STAGES-1];
    tms  = tmsSync[SYNC_STAGES-1];
    tdi  = tdiSync[SYNC_STAGES-1];
    rise = tck & ~tckPrev;
    fall = ~tck & tckPrev;
  end

  // ---------------- state machine ----------------
  tapState_t state, nextState;

  jtag_tap_fsm uFsm (
    .clk       (i_clk),
    .rst       (i_rst),
    .tms       (tms),
    .rise      (rise),
    .state     (state),
    .nextState (nextState)
  );

  assign o_tapState = state;

  // ---------------- data register selection ----------------
  logic            bypassReg;
  logic [DR_W-1:0] drShift;
  logic [IR_W-1:0] irShift;
  logic            selBypass, selIdcode, selGeneral, drLsb;
`ifdef JTAG_IDCODE_EN
  logic [31:0]     idShift;
`endif

  always_comb begin
    selBypass = (o_ir == BYPASS_OP);
`ifdef JTAG_IDCODE_EN
    selIdcode = (o_ir == IDCODE_OP);
`else
    selIdcode = 1'b0;
`endif
    selGeneral = ~selBypass & ~selIdcode;
    drLsb      = drShift[0];
    if (selBypass) drLsb = bypassReg;
`ifdef JTAG_IDCODE_EN
    else if (selIdcode) drLsb = idShift[0];
`endif
  end

  // ---------------- registers acting on TCK strobes ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bypassReg   <= 1'b0;
      drShift     <= '0;
      irShift     <= '0;
      o_ir        <= IR_DEFAULT;
      o_drOut     <= '0;
      o_tdo       <= 1'b0;
      o_drCapture <= 1'b0;
      o_drUpdate  <= 1'b0;
`ifdef JTAG_IDCODE_EN
      idShift     <= '0;
`endif
    end else begin
      o_drCapture <= 1'b0;
      o_drUpdate  <= 1'b0;

      if (rise) begin
        // actions keyed on the state being left
        case (state)
          CapDR: begin
            if (selBypass) bypassReg <= 1'b0;
            if (selGeneral) begin
              drShift     <= i_drIn;
              o_drCapture <= 1'b1;
            end
`ifdef JTAG_IDCODE_EN
            if (selIdcode) idShift <= IDCODE_VAL;
`endif
          end
          ShDR: begin
            if (selBypass)  bypassReg <= tdi;
            if (selGeneral) drShift   <= {tdi, drShift[DR_W-1:1]};
`ifdef JTAG_IDCODE_EN
            if (selIdcode)  idShift   <= {tdi, idShift[31:1]};
`endif
          end
          CapIR:   irShift <= IR_CAPTURE;
          ShIR:    irShift <= {tdi, irShift[IR_W-1:1]};
          default: ;
        endcase

        // actions keyed on the state being entered
        case (nextState)
          TLR:   o_ir <= IR_DEFAULT;
          UpdIR: o_ir <= irShift;
          UpdDR: begin
            if (selGeneral) begin
              o_drOut    <= drShift;
              o_drUpdate <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (fall) begin
        if (state == ShDR)      o_tdo <= drLsb;
        else if (state == ShIR) o_tdo <= irShift[0];
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: self-checking bench for jtag_tap_ctrl (default parameters).
// A transaction-level model tracks state, instruction, the selected DR value
// and expected strobe counts per TCK pulse. Honors JTAG_IDCODE_EN.
module tb_jtag_tap_ctrl;

  localparam int unsigned IR_W = 4;
  localparam int unsigned DR_W = 16;
  localparam int unsigned SYNC = 2;
  localparam logic [31:0] IDCODE = 32'h0000_5C11;
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] IR_DEF = 4'h1;
`else
  localparam logic [IR_W-1:0] IR_DEF = 4'hF;
`endif

  logic clk = 1'b0;
  logic i_rst, i_tck, i_tms, i_tdi;
  logic o_tdo, o_drCapture, o_drUpdate;
  logic [IR_W-1:0] o_ir;
  logic [DR_W-1:0] i_drIn, o_drOut;
  logic [3:0] o_tapState;

  always #5 clk = ~clk;

  jtag_tap_ctrl #(.IR_W(IR_W), .DR_W(DR_W), .SYNC_STAGES(SYNC), .IDCODE_VAL(IDCODE)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_tck(i_tck), .i_tms(i_tms), .i_tdi(i_tdi),
    .o_tdo(o_tdo), .o_ir(o_ir), .i_drIn(i_drIn), .o_drOut(o_drOut),
    .o_drCapture(o_drCapture), .o_drUpdate(o_drUpdate), .o_tapState(o_tapState)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- strobe monitor ----------------
  int capCnt = 0;
  int updCnt = 0;
  logic capPrev = 1'b0;
  logic updPrev = 1'b0;

  always @(negedge clk) begin
    if (o_drUpdate) begin
      updCnt++;
      check("updState", o_tapState, 8);
      check("updWidth", updPrev, 0);
    end
    if (o_drCapture) begin
      capCnt++;
      check("capState", (o_tapState == 4) || (o_tapState == 5), 1);
      check("capWidth", capPrev, 0);
    end
    updPrev = o_drUpdate;
    capPrev = o_drCapture;
  end

  // ---------------- reference model ----------------
  // state numbering: 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauseDR
  // 7 Ex2DR 8 UpdDR 9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauseIR 14 Ex2IR 15 UpdIR
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int mState, capExp, updExp;
  logic [IR_W-1:0] mIr, mIrSh;
  logic [63:0] mDr;
  logic mTdo;
  logic [DR_W-1:0] mDrOut;

  // 0 = bypass, 1 = idcode, 2 = general
  function automatic int mSel();
    if (mIr == 4'hF) return 0;
`ifdef JTAG_IDCODE_EN
    if (mIr == 4'h1) return 1;
`endif
    return 2;
  endfunction

  function automatic int mLen();
    int s = mSel();
    return (s == 0) ? 1 : (s == 1) ? 32 : DR_W;
  endfunction

  task automatic modelReset();
    mState = 0; mIr = IR_DEF; mIrSh = '0; mDr = '0; mTdo = 1'b0; mDrOut = '0;
  endtask

  task automatic modelRise(input logic tms, input logic tdi);
    int ns;
    int len = mLen();
    if (mState == 3) begin
      if (mSel() == 0) mDr = 0;
      else if (mSel() == 1) mDr = 64'(IDCODE);
      else begin mDr = 64'(i_drIn); capExp++; end
    end else if (mState == 4) begin
      mDr = (mDr >> 1) | (64'(tdi) << (len - 1));
    end else if (mState == 10) begin
      mIrSh = 4'h1;
    end else if (mState == 11) begin
      mIrSh = IR_W'((int'(mIrSh) >> 1) + (int'(tdi) << (IR_W - 1)));
    end
    ns = tms ? nxt1[mState] : nxt0[mState];
    if (ns == 0) mIr = IR_DEF;
    if (ns == 15) mIr = mIrSh;
    if (ns == 8 && mSel() == 2) begin mDrOut = mDr[DR_W-1:0]; updExp++; end
    mState = ns;
  endtask

  task automatic modelFall();
    if (mState == 4) mTdo = mDr[0];
    else if (mState == 11) mTdo = mIrSh[0];
  endtask

  // ---------------- stimulus helpers ----------------
  // One TCK pulse: 4 clk low (TMS/TDI set), 4 clk high. tdoSeen is o_tdo just
  // before the rise, i.e. the bit presented after the previous fall.
  task automatic pulseChk(input logic tms, input logic tdi, output logic tdoSeen);
    i_tms = tms; i_tdi = tdi;
    repeat (4) @(negedge clk);
    tdoSeen = o_tdo;
    check("tdo", tdoSeen, mTdo);
    i_tck = 1'b1;
    modelRise(tms, tdi);
    repeat (4) @(negedge clk);
    check("state", o_tapState, mState);
    check("ir", o_ir, mIr);
    check("drOut", o_drOut, mDrOut);
    check("capCnt", capCnt, capExp);
    check("updCnt", updCnt, updExp);
    i_tck = 1'b0;
    modelFall();
  endtask

  task automatic step(input logic tms, input logic tdi);
    logic b;
    pulseChk(tms, tdi, b);
  endtask

  // RTI -> DR scan of n bits -> RTI
  task automatic shiftDr(input logic [63:0] din, input int n, output logic [63:0] dout);
    logic b;
    step(1, 0); step(0, 0); step(0, 0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      pulseChk(i == n - 1, din[i], b);
      dout[i] = b;
    end
    step(1, 0); step(0, 0);
  endtask

  // RTI -> IR scan of n bits -> RTI
  task automatic shiftIr(input logic [63:0] din, input int n, output logic [63:0] dout);
    logic b;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      pulseChk(i == n - 1, din[i], b);
      dout[i] = b;
    end
    step(1, 0); step(0, 0);
  endtask

  typedef struct {
    logic tms;
    int   expState;
  } vec_t;

  vec_t vecs[23];

  initial begin
    logic [63:0] d;
    int c0, u0;
    logic [DR_W-1:0] outHold;

    // walk covering every state, expected states written out by hand
    vecs[0]  = '{1'b0, 1};  vecs[1]  = '{1'b1, 2};  vecs[2]  = '{1'b0, 3};
    vecs[3]  = '{1'b0, 4};  vecs[4]  = '{1'b1, 5};  vecs[5]  = '{1'b0, 6};
    vecs[6]  = '{1'b1, 7};  vecs[7]  = '{1'b0, 4};  vecs[8]  = '{1'b1, 5};
    vecs[9]  = '{1'b1, 8};  vecs[10] = '{1'b1, 2};  vecs[11] = '{1'b1, 9};
    vecs[12] = '{1'b0, 10}; vecs[13] = '{1'b1, 12}; vecs[14] = '{1'b0, 13};
    vecs[15] = '{1'b1, 14}; vecs[16] = '{1'b0, 11}; vecs[17] = '{1'b1, 12};
    vecs[18] = '{1'b1, 15}; vecs[19] = '{1'b0, 1};  vecs[20] = '{1'b1, 2};
    vecs[21] = '{1'b1, 9};  vecs[22] = '{1'b1, 0};

    i_rst = 1'b1; i_tck = 1'b0; i_tms = 1'b0; i_tdi = 1'b0; i_drIn = '0;
    capExp = 0; updExp = 0;
    modelReset();
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    check("rstState", o_tapState, 0);
    check("rstIr", o_ir, IR_DEF);
    check("rstDrOut", o_drOut, 0);
    check("rstTdo", o_tdo, 0);
    check("rstStrobes", {o_drCapture, o_drUpdate}, 0);

    for (int i = 0; i < 23; i++) begin
      i_drIn = 16'(i * 16'h1111);
      step(vecs[i].tms, i[0]);
      check("walkState", o_tapState, vecs[i].expState);
    end
    check("walkIrTlr", o_ir, IR_DEF);

    step(0, 0);  // RTI

`ifdef JTAG_IDCODE_EN
    shiftDr(64'h0, 32, d);
    check("idcodeStream", d[31:0], IDCODE);
`else
    shiftDr(64'hB4, 8, d);
    check("defBypass", d[7:0], 8'h68);
`endif

    // general DR
    shiftIr(64'h2, 4, d);
    check("irLoad2", o_ir, 4'h2);
    i_drIn = 16'hA5C3;
    c0 = capCnt; u0 = updCnt;
    shiftDr(64'h1234, 16, d);
    check("genTdo", d[15:0], 16'hA5C3);
    check("genCapOnce", capCnt - c0, 1);
    check("genUpdOnce", updCnt - u0, 1);
    check("genDrOut", o_drOut, 16'h1234);

    // BYPASS
    shiftIr(64'hF, 4, d);
    check("irLoadF", o_ir, 4'hF);
    i_drIn = 16'h5A5A;
    outHold = o_drOut;
    c0 = capCnt; u0 = updCnt;
    shiftDr(64'hB4, 8, d);
    check("bypTdo", d[7:0], 8'h68);
    check("bypDrOut", o_drOut, outHold);
    check("bypNoUpd", updCnt - u0, 0);
    check("bypNoCap", capCnt - c0, 0);

    // latency: TMS rises 3 cycles before TCK; RTI must go to SelDR
    i_tms = 1'b1;
    repeat (3) @(negedge clk);
    i_tck = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      @(negedge clk);
      check("latency", o_tapState, (k <= SYNC) ? 1 : 2);
    end
    @(negedge clk);
    i_tck = 1'b0;
    modelRise(1, 0);
    modelFall();

    // reset mid-shift: SelDR -> SelIR -> TLR -> RTI, IR = 2, 7 bits into ShDR
    step(1, 0); step(1, 0); step(0, 0);
    shiftIr(64'h2, 4, d);
    i_drIn = 16'hC0DE;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 7; i++) step(0, 1'(i));
    u0 = updCnt;
    repeat (4) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    modelReset();
    repeat (4) @(negedge clk);
    check("midRstState", o_tapState, 0);
    check("midRstIr", o_ir, IR_DEF);
    check("midRstDrOut", o_drOut, 0);
    check("midRstTdo", o_tdo, 0);
    check("midRstNoUpd", updCnt - u0, 0);

    // five TMS=1 from inside ShDR
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    check("fiveOnesState", o_tapState, 0);
    check("fiveOnesIr", o_ir, IR_DEF);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      i_drIn = 16'($urandom);
      step($urandom_range(0, 99) < 35, 1'($urandom));
    end
    for (int i = 0; i < 5; i++) step(1, 0);
    check("finalState", o_tapState, 0);
    check("finalIr", o_ir, IR_DEF);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
